// File: rtl/prj_definition.sv
// Shared project definitions: default datapath widths and the sequencer state encoding.
package prj_definition;

    // Default operand/result width and bits handled per cycle.
    localparam int DATA_WIDTH  = 32;
    localparam int CHUNK_WIDTH = 8;

    // Sequencer states: waiting, stepping through slices, one-cycle result strobe.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rc_add_chunk.sv
// CHUNK-bit ripple-carry adder built from single-bit full adders.
// Also exposes the carry into the top bit so the caller can form signed overflow.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Classic one-bit full adder.
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

module rc_add_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] sum,
    output logic             co,
    output logic             c_top
);

    // c[i] is the carry into bit i; c[CHUNK] is the carry out of the slice.
    logic [CHUNK:0] c;

    assign c[0] = ci;

    // Carry ripples from bit 0 upward through one full adder per bit.
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    assign co    = c[CHUNK];
    assign c_top = c[CHUNK-1];

endmodule

// File: rtl/rc_add_sub_seq.sv
// Sequential add/subtract: one CHUNK-bit slice per cycle through a single
// ripple-carry slice adder, LSB slice first. Subtraction is A + ~B + 1.
// Y/CO/OVF/ZERO only update when the final slice completes, so partial sums
// never become visible. WIDTH must be a multiple of CHUNK.
//
// Handshake: START is sampled on a rising edge while IDLE or DONE; operands are
// captured on that edge. DONE is a one-cycle strobe exactly N+1 cycles later,
// during which the outputs carry the new result. START while BUSY is ignored.

module rc_add_sub_seq
    import prj_definition::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int CHUNK = CHUNK_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SnA,
    output logic [WIDTH-1:0] Y,
    output logic             CO,
    output logic             OVF,
    output logic             ZERO,
    output logic             BUSY,
    output logic             DONE,
    output state_t           dbg_state
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t state, state_nxt;

    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;      // already inverted for subtract
    logic             carry;    // carry between slices
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] acc;      // partial sum, internal only
    logic [WIDTH-1:0] acc_nxt;

    logic             capture;
    logic             step;
    logic             finish;

    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic [CHUNK-1:0] slice_sum;
    logic             slice_co;
    logic             slice_ctop;

    assign dbg_state = state;

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and control strobes.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    capture   = 1'b1;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                BUSY = 1'b1;
                step = 1'b1;
                if (idx == LAST_IDX) begin
                    finish    = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                DONE = 1'b1;
                if (START) begin
                    capture   = 1'b1;
                    state_nxt = ST_BUSY;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Select the current slice of each operand and merge its sum into the accumulator.
    always_comb begin
        slice_a = opa[int'(idx) * CHUNK +: CHUNK];
        slice_b = opb[int'(idx) * CHUNK +: CHUNK];
        acc_nxt = acc;
        acc_nxt[int'(idx) * CHUNK +: CHUNK] = slice_sum;
    end

    rc_add_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a     (slice_a),
        .b     (slice_b),
        .ci    (carry),
        .sum   (slice_sum),
        .co    (slice_co),
        .c_top (slice_ctop)
    );

    // Operand capture, per-slice accumulation, and result publication on the last slice.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            acc   <= '0;
            Y     <= '0;
            CO    <= 1'b0;
            OVF   <= 1'b0;
            ZERO  <= 1'b0;
        end else if (capture) begin
            opa   <= A;
            opb   <= B ^ {WIDTH{SnA}};
            carry <= SnA;
            idx   <= '0;
            acc   <= '0;
        end else if (step) begin
            acc   <= acc_nxt;
            carry <= slice_co;
            idx   <= idx + 1'b1;
            if (finish) begin
                Y    <= acc_nxt;
                CO   <= slice_co;
                OVF  <= slice_co ^ slice_ctop;
                ZERO <= (acc_nxt == '0);
            end
        end
    end

endmodule

// File: tb/tb_rc_add_sub_seq.sv
// Bench for rc_add_sub_seq: a 32/8 instance for most scenarios and a 64/16
// instance for the wide configuration, both against an arithmetic model.
module tb_rc_add_sub_seq;
    import prj_definition::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT 32/8 ----------------
    logic        start, sna;
    logic [31:0] a, b, y;
    logic        co, ovf, zero, busy, done;
    state_t      st;

    rc_add_sub_seq #(.WIDTH(32), .CHUNK(8)) dut (
        .CLK(clk), .RST(rst_n), .START(start), .A(a), .B(b), .SnA(sna),
        .Y(y), .CO(co), .OVF(ovf), .ZERO(zero), .BUSY(busy), .DONE(done),
        .dbg_state(st)
    );

    // ---------------- DUT 64/16 ----------------
    logic        start2, sna2;
    logic [63:0] a2, b2, y2;
    logic        co2, ovf2, zero2, busy2, done2;
    state_t      st2;

    rc_add_sub_seq #(.WIDTH(64), .CHUNK(16)) dut64 (
        .CLK(clk), .RST(rst_n), .START(start2), .A(a2), .B(b2), .SnA(sna2),
        .Y(y2), .CO(co2), .OVF(ovf2), .ZERO(zero2), .BUSY(busy2), .DONE(done2),
        .dbg_state(st2)
    );

    // ---------------- scoreboard ----------------
    int vectors = 0;
    int miscompares = 0;
    logic [66:0] exp_q[$];      // {co, ovf, zero, y[63:0]}
    logic [31:0] last_y32 = '0; // last delivered result, for hold checks
    logic [63:0] last_y64 = '0;

    // Arithmetic reference: plain modular add of A and (B or its negation).
    function automatic logic [66:0] model_op(input int w, input logic [63:0] ia,
                                             input logic [63:0] ib, input logic s);
        logic [64:0] mask, aa, bb, sum;
        logic [63:0] yy;
        logic        c, o, sa, sb, sy;
        mask = (65'd1 << w) - 65'd1;
        aa   = {1'b0, ia} & mask;
        bb   = {1'b0, ib} & mask;
        if (s) sum = aa + ((mask - bb) + 65'd1);  // A - B as A + 2^w - B
        else   sum = aa + bb;
        if (s && bb == 0) sum = aa + (65'd1 << w); // A - 0 produces a carry
        yy = sum[63:0] & mask[63:0];
        c  = sum[w];
        sa = aa[w-1];
        sb = bb[w-1];
        sy = yy[w-1];
        o  = s ? (sa != sb && sy != sa) : (sa == sb && sy != sa);
        return {c, o, (yy == 64'd0), yy};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic run32(input logic [31:0] ta, input logic [31:0] tb_,
                         input logic ts, input bit poke, input string name);
        logic [66:0] exp;
        int lat;
        exp_q.push_back(model_op(32, {32'd0, ta}, {32'd0, tb_}, ts));
        a = ta; b = tb_; sna = ts; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; sna = 1'($urandom_range(0, 1));
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            vectors++;
            if (busy !== 1'b1 || y !== last_y32) begin
                miscompares++;
                $display("FAIL %s busy/hold: busy=%b y=%h, required busy=1 y=%h", name, busy, y, last_y32);
            end
            if (poke) begin
                start = 1'($urandom_range(0, 1));
                a = $urandom; b = $urandom; sna = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        exp = exp_q.pop_front();
        vectors++;
        if (lat != 5) begin
            miscompares++;
            $display("FAIL %s latency: got %0d cycles, required 5", name, lat);
        end
        vectors++;
        if ({co, ovf, zero, 32'd0, y} !== exp || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s result: got y=%h co=%b ovf=%b zero=%b busy=%b, required y=%h co=%b ovf=%b zero=%b busy=0",
                     name, y, co, ovf, zero, busy, exp[31:0], exp[66], exp[65], exp[64]);
        end
        last_y32 = exp[31:0];
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || y !== last_y32) begin
            miscompares++;
            $display("FAIL %s after-done: done=%b busy=%b y=%h, required 0 0 %h", name, done, busy, y, last_y32);
        end
    endtask

    task automatic run64(input logic [63:0] ta, input logic [63:0] tb_,
                         input logic ts, input string name);
        logic [66:0] exp;
        int lat;
        exp_q.push_back(model_op(64, ta, tb_, ts));
        a2 = ta; b2 = tb_; sna2 = ts; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom};
        lat = 1;
        while (done2 !== 1'b1 && lat < 20) begin
            vectors++;
            if (busy2 !== 1'b1 || y2 !== last_y64) begin
                miscompares++;
                $display("FAIL %s busy/hold: busy=%b y=%h, required busy=1 y=%h", name, busy2, y2, last_y64);
            end
            @(posedge clk); #1;
            lat++;
        end
        exp = exp_q.pop_front();
        vectors++;
        if (lat != 5) begin
            miscompares++;
            $display("FAIL %s latency: got %0d cycles, required 5", name, lat);
        end
        vectors++;
        if ({co2, ovf2, zero2, y2} !== exp) begin
            miscompares++;
            $display("FAIL %s result: got y=%h co=%b ovf=%b zero=%b, required y=%h co=%b ovf=%b zero=%b",
                     name, y2, co2, ovf2, zero2, exp[63:0], exp[66], exp[65], exp[64]);
        end
        last_y64 = exp[63:0];
        @(posedge clk); #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1;
        vectors++;
        if ({y, co, ovf, zero, busy, done} !== '0 || st !== ST_IDLE ||
            {y2, co2, ovf2, zero2, busy2, done2} !== '0) begin
            miscompares++;
            $display("FAIL reset: y=%h co=%b ovf=%b zero=%b busy=%b done=%b y64=%h, required all 0",
                     y, co, ovf, zero, busy, done, y2);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run32(32'd5, 32'd3, 1'b0, 0, "add_5_3");
        run32(32'd3, 32'd5, 1'b1, 0, "sub_3_5");
        run32(32'h12345678, 32'h12345678, 1'b1, 0, "sub_equal");
        run32(32'h7FFFFFFF, 32'd1, 1'b0, 0, "add_ovf");
        run32(32'h80000000, 32'd1, 1'b1, 0, "sub_ovf");
        run32(32'hFFFFFFFF, 32'd1, 1'b0, 0, "add_wrap");
        run32(32'd0, 32'd0, 1'b1, 0, "sub_zero");
    endtask

    task automatic test_random();
        logic [31:0] corner[6];
        logic [31:0] ra, rb;
        corner[0] = 32'h0; corner[1] = 32'hFFFFFFFF; corner[2] = 32'h80000000;
        corner[3] = 32'h7FFFFFFF; corner[4] = 32'h000000FF; corner[5] = 32'h00FF00FF;
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            run32(ra, rb, 1'($urandom_range(0, 1)), 0, "random");
        end
    endtask

    task automatic test_busy_ignore();
        for (int i = 0; i < 6; i++)
            run32($urandom, $urandom, 1'($urandom_range(0, 1)), 1, "busy_ignore");
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a_2, b_2;
        logic s1, s2;
        logic [66:0] e1, e2;
        int lat;
        a1 = $urandom; b1 = $urandom; s1 = 1'($urandom_range(0, 1));
        a_2 = $urandom; b_2 = $urandom; s2 = 1'($urandom_range(0, 1));
        e1 = model_op(32, {32'd0, a1}, {32'd0, b1}, s1);
        e2 = model_op(32, {32'd0, a_2}, {32'd0, b_2}, s2);
        a = a1; b = b1; sna = s1; start = 1'b1;
        @(posedge clk); #1;
        a = a_2; b = b_2; sna = s2;           // START stays high throughout
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
        vectors++;
        if (lat != 5 || {co, ovf, zero, 32'd0, y} !== e1) begin
            miscompares++;
            $display("FAIL b2b first: lat=%0d y=%h co=%b ovf=%b zero=%b, required lat=5 y=%h co=%b ovf=%b zero=%b",
                     lat, y, co, ovf, zero, e1[31:0], e1[66], e1[65], e1[64]);
        end
        @(posedge clk); #1;
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b restart: busy=%b done=%b, required busy=1 done=0", busy, done);
        end
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
        vectors++;
        if (lat != 5 || {co, ovf, zero, 32'd0, y} !== e2) begin
            miscompares++;
            $display("FAIL b2b second: lat=%0d y=%h co=%b ovf=%b zero=%b, required lat=5 y=%h co=%b ovf=%b zero=%b",
                     lat, y, co, ovf, zero, e2[31:0], e2[66], e2[65], e2[64]);
        end
        last_y32 = e2[31:0];
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        int seen;
        run32(32'd5, 32'd3, 1'b0, 0, "pre_abort");    // leaves Y nonzero
        a = 32'h11111111; b = 32'h22222222; sna = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;                           // second BUSY cycle
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({y, co, ovf, zero, busy, done} !== '0 || st !== ST_IDLE) begin
            miscompares++;
            $display("FAIL abort_reset: y=%h co=%b ovf=%b zero=%b busy=%b done=%b, required all 0",
                     y, co, ovf, zero, busy, done);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_y32 = '0;
        last_y64 = '0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1 || busy === 1'b1) seen++;
            @(posedge clk); #1;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL abort_no_done: saw %0d busy/done cycles, required 0", seen);
        end
        run32(32'd5, 32'd3, 1'b0, 0, "after_abort");
    endtask

    task automatic test_wide();
        run64(64'hFFFFFFFFFFFFFFFF, 64'd1, 1'b0, "wide_wrap");
        run64(64'h7FFFFFFFFFFFFFFF, 64'd1, 1'b0, "wide_ovf");
        for (int i = 0; i < 8; i++)
            run64({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), "wide_random");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        start = 1'b0; sna = 1'b0; a = '0; b = '0;
        start2 = 1'b0; sna2 = 1'b0; a2 = '0; b2 = '0;
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        test_wide();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time limit in case a scenario stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rc_add_sub_seq.md
RC_ADD_SUB_SEQ -- requirements
Module: rc_add_sub_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 8, bits processed per cycle; WIDTH SHALL be a multiple of CHUNK.
REQ-003 SHALL have CLK  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have RST  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have START  input  1  request a new operation.
REQ-006 SHALL have A  input  WIDTH  operand A.
REQ-007 SHALL have B  input  WIDTH  operand B.
REQ-008 SHALL have SnA  input  1  0 = add, 1 = subtract (A - B).
REQ-009 SHALL have Y  output  WIDTH  result, registered.
REQ-010 SHALL have CO  output  1  carry out of MSB; for subtract, 1 = no borrow.
REQ-011 SHALL have OVF  output  1  signed two's-complement overflow.
REQ-012 SHALL have ZERO  output  1  Y equals 0.
REQ-013 SHALL have BUSY  output  1  operation in progress.
REQ-014 SHALL have DONE  output  1  one-cycle pulse, result valid.

Function
REQ-015 SHALL implement states IDLE, BUSY, DONE; N = WIDTH/CHUNK.
REQ-016 IDLE or DONE with START=1 at an edge SHALL capture A, B XOR {WIDTH{SnA}}, and carry-in = SnA, clear the chunk index, and enter BUSY.
REQ-017 BUSY SHALL add one CHUNK slice per cycle, LSB slice first, propagating carry between slices in a register; chunk index increments each cycle.
REQ-018 After slice N-1 is processed, SHALL write Y/CO/OVF/ZERO together and enter DONE; DONE=1 exactly N+1 cycles after the START sampling edge.
REQ-019 DONE state SHALL last one cycle, then IDLE unless START=1 (back-to-back, REQ-016).
REQ-020 START while BUSY SHALL be ignored; A, B, SnA changes after capture SHALL not affect the result.
REQ-021 BUSY output SHALL equal (state == BUSY).
REQ-022 OVF SHALL equal carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-023 Y, CO, OVF, ZERO SHALL hold the last completed result from DONE until the next DONE; partial sums SHALL never appear on Y.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH; no saturation.

Reset
REQ-025 RST=0 SHALL immediately force IDLE and Y=0, CO=0, OVF=0, ZERO=0, BUSY=0, DONE=0, internal carry/index/operands 0.
REQ-026 Reset during BUSY SHALL abort the operation with no DONE pulse; first START after release SHALL behave as from power-up.

Structure
REQ-027 DATA_WIDTH default (32) and the state encoding SHALL be defined in the shared prj_definition package.
REQ-028 One sub-module rc_add_chunk SHALL implement a CHUNK-bit ripple carry adder from FULL_ADDER instances, outputting sum, carry out, and carry into its top bit.
REQ-029 The datapath SHALL instantiate exactly one rc_add_chunk, with slice selection muxed by the chunk index.

Verification (WIDTH=32, CHUNK=8 unless stated)
REQ-030 A=5, B=3, SnA=0, START pulse -> BUSY for 4 cycles, DONE on 5th, Y=0x00000008, CO=0, OVF=0, ZERO=0.
REQ-031 A=3, B=5, SnA=1 -> Y=0xFFFFFFFE, CO=0, OVF=0; A=0x12345678, B=0x12345678, SnA=1 -> Y=0, ZERO=1, CO=1.
REQ-032 A=0x7FFFFFFF, B=1, SnA=0 -> Y=0x80000000, OVF=1, CO=0; A=0x80000000, B=1, SnA=1 -> Y=0x7FFFFFFF, OVF=1, CO=1.
REQ-033 Reset during 2nd BUSY cycle -> all outputs 0 immediately, no DONE; START pulsed during BUSY and operands changed after capture -> ignored, original result delivered.
REQ-034 START held high across DONE -> second operation starts without an IDLE cycle, DONE pulses 5 cycles apart; each result correct.
REQ-035 WIDTH=64, CHUNK=16: A=0xFFFFFFFFFFFFFFFF, B=1, SnA=0 -> DONE after 5 cycles, Y=0, CO=1, ZERO=1, OVF=0.
